// File: rtl/peripheral_pipeline_bridge_if.sv
// Memory-mapped command/response bus with waitrequest flow control and
// pipelined read returns. The bridge uses two instances of it:
//   - upstream, through the slave modport (the bridge receives commands);
//   - downstream, through the master modport (the bridge issues commands).
// Signals:
//   address/byteenable/read/write/writedata : command, driven by the master
//   waitrequest                             : command stall, driven by the slave
//   readdata/readdatavalid/endofpacket      : read return, driven by the slave
interface peripheral_pipeline_bridge_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              endofpacket;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid, endofpacket
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid, endofpacket
  );
endinterface

// File: rtl/peripheral_pipeline_bridge.sv
// Pipeline bridge between an upstream command port and a downstream master.
//
// Commands are queued in a command FIFO and replayed to the downstream side
// from an output register. Reads are credit-limited by MAX_PENDING. Read
// returns are buffered in a response FIFO and handed back upstream one word
// per cycle, in issue order.
//
// Ports:
//   slave_clk, slave_reset_n : clock; asynchronous active-low reset
//   slave_bus                : upstream port (word address, ADDR_W bits)
//   master_bus               : downstream port (byte address, ADDR_W+BL bits)
//   pending_count            : reads issued downstream and not yet returned upstream
//   unsolicited_err          : sticky; set by a read return with no read outstanding

// Synchronous FIFO. The pointers wrap modulo DEPTH, and a separate
// occupancy count tells full apart from empty.
module ppb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [AW:0]   cnt
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          push_ok, pop_ok;

  assign push_ok = push & (cnt != (AW+1)'(DEPTH));
  assign pop_ok  = pop & (cnt != '0);
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok)  rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end
endmodule

module peripheral_pipeline_bridge #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int CMD_DEPTH   = 8,
  parameter int RSP_DEPTH   = 16,
  parameter int MAX_PENDING = 8,
  localparam int BE_W       = DATA_W / 8,
  localparam int BL         = $clog2(BE_W),
  localparam int PW         = $clog2(MAX_PENDING) + 1
) (
  input  logic                         slave_clk,
  input  logic                         slave_reset_n,
  peripheral_pipeline_bridge_if.slave  slave_bus,
  peripheral_pipeline_bridge_if.master master_bus,
  output logic [PW-1:0]                pending_count,
  output logic                         unsolicited_err
);
  localparam int MAW = ADDR_W + BL;
  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int RCW = $clog2(RSP_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic              rd;
    logic              wr;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              eop;
  } rsp_t;

  cmd_t           cmd_in, cmd_head;
  logic [CCW-1:0] cmd_cnt;
  logic           cmd_push, cmd_pop, cmd_full, cmd_empty;

  rsp_t           rsp_in, rsp_head;
  logic [RCW-1:0] rsp_cnt;
  logic           rsp_push, rsp_pop;

  logic              m_rd, m_wr;
  logic [MAW-1:0]    m_addr;
  logic [BE_W-1:0]   m_be;
  logic [DATA_W-1:0] m_wdata;

  logic              s_rdv, s_eop;
  logic [DATA_W-1:0] s_rdata;

  logic [PW-1:0] pend_nxt, mst_out;
  logic          out_stall, rd_done, can_issue, rdv_ok;

  // ---------------------------------------------------------------- command side
  // The output register is treated as the last of the CMD_DEPTH slots, so
  // exactly CMD_DEPTH commands are accepted before stalling while downstream
  // is blocked. Full is taken from registered state only: a pop in the same
  // cycle does not open a slot until the next cycle.
  assign cmd_full  = (cmd_cnt + CCW'(m_rd | m_wr)) >= CCW'(CMD_DEPTH);
  assign cmd_empty = (cmd_cnt == '0);
  assign slave_bus.waitrequest = cmd_full;

  assign cmd_push = (slave_bus.read | slave_bus.write) & ~cmd_full;
  // When read and write are both asserted, only the write is kept.
  assign cmd_in = '{wdata: slave_bus.writedata,
                    addr:  slave_bus.address,
                    be:    slave_bus.byteenable,
                    rd:    slave_bus.read & ~slave_bus.write,
                    wr:    slave_bus.write};

  ppb_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(slave_clk), .rst_n(slave_reset_n),
    .push(cmd_push), .din(cmd_in),
    .pop(cmd_pop), .dout(cmd_head), .cnt(cmd_cnt)
  );

  // ---------------------------------------------------------------- issue stage
  assign out_stall = (m_rd | m_wr) & master_bus.waitrequest;
  assign rd_done   = m_rd & ~master_bus.waitrequest;
  assign rsp_pop   = (rsp_cnt != '0);

  // Credits are checked against the count as it will be on the cycle the
  // read appears downstream. A read without a credit blocks the head, so
  // later writes cannot overtake it.
  assign pend_nxt  = pending_count + PW'(rd_done) - PW'(rsp_pop);
  assign can_issue = ~cmd_empty & (~cmd_head.rd | (pend_nxt < PW'(MAX_PENDING)));
  assign cmd_pop   = ~out_stall & can_issue;

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_be    <= '0;
      m_wdata <= '0;
    end else if (!out_stall) begin
      m_rd <= cmd_pop & cmd_head.rd;
      m_wr <= cmd_pop & cmd_head.wr;
      if (cmd_pop) begin
        m_addr  <= MAW'(cmd_head.addr) << BL;
        m_be    <= cmd_head.be;
        m_wdata <= cmd_head.wdata;
      end
    end
  end

  assign master_bus.read       = m_rd;
  assign master_bus.write      = m_wr;
  assign master_bus.address    = m_addr;
  assign master_bus.byteenable = m_be;
  assign master_bus.writedata  = m_wdata;

  // ---------------------------------------------------------------- response side
  // mst_out counts reads accepted downstream but not yet returned there; a
  // return while it is zero (including one that arrives after a reset) is
  // dropped and flagged.
  assign rdv_ok   = master_bus.readdatavalid & (mst_out != '0);
  assign rsp_push = rdv_ok;
  assign rsp_in   = '{data: master_bus.readdata, eop: master_bus.endofpacket};

  // Credits never exceed RSP_DEPTH, so this FIFO cannot overflow.
  ppb_fifo #(.W($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(slave_clk), .rst_n(slave_reset_n),
    .push(rsp_push), .din(rsp_in),
    .pop(rsp_pop), .dout(rsp_head), .cnt(rsp_cnt)
  );

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      pending_count   <= '0;
      mst_out         <= '0;
      unsolicited_err <= 1'b0;
      s_rdv           <= 1'b0;
      s_eop           <= 1'b0;
      s_rdata         <= '0;
    end else begin
      pending_count <= pend_nxt;
      mst_out       <= mst_out + PW'(rd_done) - PW'(rdv_ok);
      if (master_bus.readdatavalid && mst_out == '0) unsolicited_err <= 1'b1;
      s_rdv <= rsp_pop;
      if (rsp_pop) begin
        s_rdata <= rsp_head.data;
        s_eop   <= rsp_head.eop;
      end
    end
  end

  assign slave_bus.readdata      = s_rdata;
  assign slave_bus.readdatavalid = s_rdv;
  assign slave_bus.endofpacket   = s_eop;
endmodule

// File: tb/tb_peripheral_pipeline_bridge.sv
// Directed bench for peripheral_pipeline_bridge with the default parameters
// (DATA_W=32, ADDR_W=9, CMD_DEPTH=8, RSP_DEPTH=16, MAX_PENDING=8).
// Inputs change 1 time unit after each rising edge and outputs are sampled there.
module tb_peripheral_pipeline_bridge;
  logic       slave_clk = 1'b0;
  logic       slave_reset_n = 1'b0;
  logic [3:0] pending_count;
  logic       unsolicited_err;
  int         errors = 0;
  int         checks = 0;
  int         rd_issued = 0;

  peripheral_pipeline_bridge_if #(.ADDR_W(9),  .DATA_W(32)) sbus ();
  peripheral_pipeline_bridge_if #(.ADDR_W(11), .DATA_W(32)) mbus ();

  peripheral_pipeline_bridge dut (
    .slave_clk       (slave_clk),
    .slave_reset_n   (slave_reset_n),
    .slave_bus       (sbus),
    .master_bus      (mbus),
    .pending_count   (pending_count),
    .unsolicited_err (unsolicited_err)
  );

  always #5 slave_clk = ~slave_clk;

  // Counts reads accepted downstream.
  always @(posedge slave_clk) if (mbus.read && !mbus.waitrequest) rd_issued <= rd_issued + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge slave_clk);
    #1;
  endtask

  task automatic apply_reset();
    slave_reset_n = 1'b0;
    sbus.read = 0; sbus.write = 0;
    mbus.readdatavalid = 0; mbus.waitrequest = 0;
    tick(); tick();
    slave_reset_n = 1'b1;
    tick();
  endtask

  // Presents one command and returns just after the edge that accepts it.
  task automatic send(input logic rd, input logic wr, input logic [8:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    sbus.read = rd; sbus.write = wr; sbus.address = a;
    sbus.writedata = d; sbus.byteenable = be;
    while (sbus.waitrequest && n < 50) begin tick(); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL send_timeout: waitrequest stuck at 1, expected release"); end
    tick();
    sbus.read = 0; sbus.write = 0;
  endtask

  task automatic test_reset();
    sbus.read = 0; sbus.write = 0; sbus.address = '0; sbus.writedata = '0; sbus.byteenable = '0;
    mbus.waitrequest = 0; mbus.readdata = '0; mbus.readdatavalid = 0; mbus.endofpacket = 0;
    #3;
    checks++; if (sbus.waitrequest !== 1'b0) begin errors++; $display("FAIL rst_waitreq got=%b exp=0", sbus.waitrequest); end
    checks++; if (mbus.read !== 1'b0 || mbus.write !== 1'b0) begin errors++; $display("FAIL rst_mcmd got=%b%b exp=00", mbus.read, mbus.write); end
    checks++; if (sbus.readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv got=%b exp=0", sbus.readdatavalid); end
    checks++; if (pending_count !== 4'd0) begin errors++; $display("FAIL rst_pending got=%0d exp=0", pending_count); end
    checks++; if (unsolicited_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", unsolicited_err); end
    apply_reset();
  endtask

  task automatic test_write();
    mbus.waitrequest = 0;
    sbus.write = 1; sbus.address = 9'h005; sbus.writedata = 32'hDEADBEEF; sbus.byteenable = 4'hF;
    checks++; if (sbus.waitrequest !== 1'b0) begin errors++; $display("FAIL wr_waitreq0 got=%b exp=0", sbus.waitrequest); end
    tick();
    sbus.write = 0;
    checks++; if (mbus.write !== 1'b0) begin errors++; $display("FAIL wr_early got=%b exp=0", mbus.write); end
    tick();
    checks++; if (mbus.write !== 1'b1 || mbus.read !== 1'b0) begin errors++; $display("FAIL wr_cmd got=%b%b exp=01", mbus.read, mbus.write); end
    checks++; if (mbus.address !== 11'h014) begin errors++; $display("FAIL wr_addr got=%h exp=014", mbus.address); end
    checks++; if (mbus.writedata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data got=%h exp=deadbeef", mbus.writedata); end
    checks++; if (mbus.byteenable !== 4'hF) begin errors++; $display("FAIL wr_be got=%h exp=f", mbus.byteenable); end
    checks++; if (sbus.waitrequest !== 1'b0) begin errors++; $display("FAIL wr_waitreq1 got=%b exp=0", sbus.waitrequest); end
    tick();
    checks++; if (mbus.write !== 1'b0) begin errors++; $display("FAIL wr_done got=%b exp=0", mbus.write); end
  endtask

  task automatic test_back_to_back();
    mbus.waitrequest = 0;
    for (int i = 0; i < 4; i++) begin
      sbus.write = 1; sbus.address = 9'(16 + i); sbus.writedata = 32'hB0 + 32'(i); sbus.byteenable = 4'hF;
      checks++; if (sbus.waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_waitreq i=%0d got=1 exp=0", i); end
      tick();
      if (i >= 1) begin
        checks++; if (mbus.write !== 1'b1 || mbus.writedata !== 32'hB0 + 32'(i - 1))
          begin errors++; $display("FAIL b2b_data i=%0d got=%b/%h exp=1/%h", i, mbus.write, mbus.writedata, 32'hB0 + 32'(i - 1)); end
      end
    end
    sbus.write = 0;
    tick();
    checks++; if (mbus.write !== 1'b1 || mbus.writedata !== 32'hB3) begin errors++; $display("FAIL b2b_last got=%b/%h exp=1/b3", mbus.write, mbus.writedata); end
    tick();
    checks++; if (mbus.write !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", mbus.write); end
  endtask

  task automatic test_rw_both();
    int base = rd_issued;
    send(1'b1, 1'b1, 9'h007, 32'hCAFE0007, 4'h3);
    tick();
    checks++; if (mbus.write !== 1'b1 || mbus.read !== 1'b0) begin errors++; $display("FAIL rw_cmd got=%b%b exp=01", mbus.read, mbus.write); end
    checks++; if (mbus.address !== 11'h01C || mbus.byteenable !== 4'h3) begin errors++; $display("FAIL rw_addr got=%h/%h exp=01c/3", mbus.address, mbus.byteenable); end
    tick(); tick();
    checks++; if (pending_count !== 4'd0 || rd_issued != base) begin errors++; $display("FAIL rw_noread pend=%0d reads=%0d exp=0/0", pending_count, rd_issued - base); end
  endtask

  task automatic test_fill();
    int k = 0;
    logic acc;
    mbus.waitrequest = 1;
    for (int i = 0; i < 8; i++) send(1'b0, 1'b1, 9'(i), 32'h100 + 32'(i), 4'hF);
    checks++; if (sbus.waitrequest !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", sbus.waitrequest); end
    sbus.write = 1; sbus.address = 9'd8; sbus.writedata = 32'h108; sbus.byteenable = 4'hF;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (sbus.waitrequest !== 1'b1) begin errors++; $display("FAIL fill_hold_wr c=%0d got=0 exp=1", c); end
      checks++; if (mbus.write !== 1'b1 || mbus.writedata !== 32'h100 || mbus.address !== 11'h000)
        begin errors++; $display("FAIL fill_stable c=%0d got=%b/%h/%h exp=1/100/000", c, mbus.write, mbus.writedata, mbus.address); end
    end
    mbus.waitrequest = 0;
    for (int c = 0; c < 40 && k < 9; c++) begin
      if (mbus.write) begin
        checks++; if (mbus.writedata !== 32'h100 + 32'(k) || mbus.address !== 11'(k * 4))
          begin errors++; $display("FAIL fill_order k=%0d got=%h/%h exp=%h/%h", k, mbus.writedata, mbus.address, 32'h100 + 32'(k), 11'(k * 4)); end
        k++;
      end
      acc = sbus.write && !sbus.waitrequest;
      tick();
      if (acc) sbus.write = 0;
    end
    checks++; if (k != 9) begin errors++; $display("FAIL fill_count got=%0d exp=9", k); end
  endtask

  task automatic test_credit();
    int base = rd_issued;
    mbus.waitrequest = 0;
    for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 9'h20 + 9'(i), 32'h0, 4'hF);
    repeat (10) tick();
    checks++; if (rd_issued - base != 8) begin errors++; $display("FAIL cr_issued got=%0d exp=8", rd_issued - base); end
    checks++; if (pending_count !== 4'd8) begin errors++; $display("FAIL cr_pend8 got=%0d exp=8", pending_count); end
    checks++; if (mbus.read !== 1'b0) begin errors++; $display("FAIL cr_hold got=%b exp=0", mbus.read); end
    mbus.readdatavalid = 1; mbus.readdata = 32'hA5A50001; mbus.endofpacket = 0;
    tick();
    mbus.readdatavalid = 0;
    checks++; if (mbus.read !== 1'b0 || sbus.readdatavalid !== 1'b0) begin errors++; $display("FAIL cr_ret0 got=%b/%b exp=0/0", mbus.read, sbus.readdatavalid); end
    tick();
    checks++; if (sbus.readdatavalid !== 1'b1 || sbus.readdata !== 32'hA5A50001) begin errors++; $display("FAIL cr_rsp got=%b/%h exp=1/a5a50001", sbus.readdatavalid, sbus.readdata); end
    checks++; if (pending_count !== 4'd7) begin errors++; $display("FAIL cr_pend7 got=%0d exp=7", pending_count); end
    checks++; if (mbus.read !== 1'b1 || mbus.address !== 11'h0A0) begin errors++; $display("FAIL cr_ninth got=%b/%h exp=1/0a0", mbus.read, mbus.address); end
    tick();
    checks++; if (pending_count !== 4'd8 || mbus.read !== 1'b0) begin errors++; $display("FAIL cr_refill got=%0d/%b exp=8/0", pending_count, mbus.read); end
    checks++; if (rd_issued - base != 9) begin errors++; $display("FAIL cr_issued9 got=%0d exp=9", rd_issued - base); end
  endtask

  task automatic test_read_return();
    mbus.waitrequest = 0;
    send(1'b1, 1'b0, 9'h003, 32'h0, 4'hF);
    tick();
    checks++; if (mbus.read !== 1'b1 || mbus.address !== 11'h00C) begin errors++; $display("FAIL rr_cmd got=%b/%h exp=1/00c", mbus.read, mbus.address); end
    tick();
    checks++; if (pending_count !== 4'd1 || mbus.read !== 1'b0) begin errors++; $display("FAIL rr_pend1 got=%0d/%b exp=1/0", pending_count, mbus.read); end
    mbus.readdatavalid = 1; mbus.readdata = 32'h12345678; mbus.endofpacket = 1;
    tick();
    mbus.readdatavalid = 0; mbus.endofpacket = 0;
    checks++; if (sbus.readdatavalid !== 1'b0) begin errors++; $display("FAIL rr_early got=%b exp=0", sbus.readdatavalid); end
    tick();
    checks++; if (sbus.readdatavalid !== 1'b1 || sbus.readdata !== 32'h12345678 || sbus.endofpacket !== 1'b1)
      begin errors++; $display("FAIL rr_rsp got=%b/%h/%b exp=1/12345678/1", sbus.readdatavalid, sbus.readdata, sbus.endofpacket); end
    checks++; if (pending_count !== 4'd0) begin errors++; $display("FAIL rr_pend0 got=%0d exp=0", pending_count); end
    tick();
    checks++; if (sbus.readdatavalid !== 1'b0) begin errors++; $display("FAIL rr_single got=%b exp=0", sbus.readdatavalid); end
  endtask

  task automatic test_unsolicited();
    int n = 0;
    mbus.readdatavalid = 1; mbus.readdata = 32'h00000BAD;
    tick();
    mbus.readdatavalid = 0;
    checks++; if (unsolicited_err !== 1'b1) begin errors++; $display("FAIL us_err got=%b exp=1", unsolicited_err); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (sbus.readdatavalid !== 1'b0 || pending_count !== 4'd0) begin errors++; $display("FAIL us_drop c=%0d got=%b/%0d exp=0/0", c, sbus.readdatavalid, pending_count); end
    end
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 9'h40 + 9'(i), 32'h0, 4'hF);
    while (pending_count !== 4'd3 && n < 20) begin tick(); n++; end
    checks++; if (pending_count !== 4'd3) begin errors++; $display("FAIL us_pend3 got=%0d exp=3", pending_count); end
    #2;
    slave_reset_n = 1'b0;
    #1;
    checks++; if (mbus.read !== 1'b0 || mbus.write !== 1'b0 || mbus.address !== 11'h0)
      begin errors++; $display("FAIL ar_master got=%b%b/%h exp=00/000", mbus.read, mbus.write, mbus.address); end
    checks++; if (sbus.readdatavalid !== 1'b0 || sbus.readdata !== 32'h0 || sbus.waitrequest !== 1'b0)
      begin errors++; $display("FAIL ar_slave got=%b/%h/%b exp=0/0/0", sbus.readdatavalid, sbus.readdata, sbus.waitrequest); end
    checks++; if (pending_count !== 4'd0 || unsolicited_err !== 1'b0) begin errors++; $display("FAIL ar_status got=%0d/%b exp=0/0", pending_count, unsolicited_err); end
    tick();
    slave_reset_n = 1'b1;
    tick();
    mbus.readdatavalid = 1; mbus.readdata = 32'h1A7E;
    tick();
    mbus.readdatavalid = 0;
    checks++; if (unsolicited_err !== 1'b1) begin errors++; $display("FAIL late_err got=%b exp=1", unsolicited_err); end
    tick();
    checks++; if (sbus.readdatavalid !== 1'b0 || pending_count !== 4'd0) begin errors++; $display("FAIL late_drop got=%b/%0d exp=0/0", sbus.readdatavalid, pending_count); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_rw_both();
    test_fill();
    apply_reset();
    test_credit();
    apply_reset();
    test_read_return();
    test_unsolicited();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/peripheral_pipeline_bridge.md
PERIPHERAL_PIPELINE_BRIDGE -- requirements
Module: peripheral_pipeline_bridge

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, data width in bits; 8/16/32/64.
- ADDR_W, 9, slave word-address width.
- CMD_DEPTH, 8, command FIFO entries; power of two, >=2.
- RSP_DEPTH, 16, response FIFO entries; power of two, >=2.
- MAX_PENDING, 8, read credit limit; 1..RSP_DEPTH.

REQ-002 Ports SHALL be, one per line: name direction width meaning. BE_W = DATA_W/8 and BL = log2(BE_W).
- slave_clk in 1: single clock for both sides.
- slave_reset_n in 1: reset, asynchronous, active-low.
- slave_address in ADDR_W: word address.
- slave_byteenable in BE_W: byte lanes.
- slave_read / slave_write in 1: commands.
- slave_writedata in DATA_W: write data.
- slave_waitrequest out 1: command stall.
- slave_readdata out DATA_W: returned data.
- slave_readdatavalid out 1: return strobe.
- slave_endofpacket out 1: EOP travelling with the data.
- master_address out ADDR_W+BL: byte address.
- master_byteenable out BE_W: byte lanes.
- master_read / master_write out 1: commands.
- master_writedata out DATA_W: write data.
- master_waitrequest in 1: downstream stall.
- master_readdata in DATA_W: read data.
- master_readdatavalid in 1: read strobe.
- master_endofpacket in 1: EOP.
- pending_count out log2(MAX_PENDING)+1: read credits in use.
- unsolicited_err out 1: sticky error flag.

Function
REQ-003 The command FIFO SHALL store {writedata, address, byteenable, read, write}. Each slave_read|slave_write cycle with slave_waitrequest low SHALL push exactly one entry.
REQ-004 slave_waitrequest SHALL equal cmd-FIFO-full combinationally. There SHALL be no bypass when full, even if a pop occurs in the same cycle.
REQ-005 If slave_read and slave_write are both high, the bridge SHALL store a write only; the read is discarded.
REQ-006 Master outputs SHALL be driven from an output register loaded from the FIFO head.
- Empty FIFO with credit available: a command accepted at edge T SHALL assert on master at edge T+1.
REQ-007 While master_waitrequest is high with a command asserted, all master outputs SHALL hold stable.
- A command completes on the first edge with master_waitrequest low.
- A new command MAY be presented on the next cycle, giving back-to-back throughput of one per cycle.
REQ-008 master_address SHALL equal {stored address, BL zeros}.
REQ-009 A read SHALL issue only if pending_count < MAX_PENDING. Otherwise the read stalls at the head and later writes SHALL NOT overtake it; ordering is strict.
REQ-010 pending_count SHALL update as follows:
- +1 on read completion (master_read & !master_waitrequest).
- -1 when slave_readdatavalid is asserted.
- Unchanged when both occur in the same cycle.
REQ-011 Each master_readdatavalid with pending reads SHALL push {readdata, endofpacket} into the response FIFO. Because of the credit limit (MAX_PENDING <= RSP_DEPTH) the response FIFO cannot overflow.
REQ-012 A non-empty response FIFO SHALL pop one word per cycle. slave_readdata, slave_endofpacket and slave_readdatavalid SHALL be registered, asserting on the edge after the word was written; latency is 1 cycle when empty.
REQ-013 Responses SHALL return in issue order, with no gaps while the FIFO is non-empty.
REQ-014 A master_readdatavalid arriving when no read is pending SHALL be dropped and SHALL set unsolicited_err. The flag stays set until reset.
- "No read pending" means the number of issued reads not yet returned on master is zero.
REQ-015 The FIFO read and write pointers SHALL wrap modulo depth. A full-depth occupancy count SHALL be carried so that full and empty are distinguishable.

Reset
REQ-016 Asserting slave_reset_n low SHALL asynchronously:
- empty both FIFOs;
- clear pending_count and unsolicited_err;
- drive all outputs to 0 (slave_waitrequest 0, master_read 0, master_write 0, slave_readdatavalid 0).
REQ-017 On reset mid-operation:
- in-flight commands and pending responses SHALL be discarded;
- a late master_readdatavalid after release SHALL be treated as unsolicited (REQ-014).
REQ-018 Outputs SHALL change only on slave_clk edges after reset release. The exception is slave_waitrequest, which follows REQ-004.

Verification
REQ-019 Write 0xDEADBEEF to address 0x05 with be=0xF and master_waitrequest low. Required: master_write at T+1 with master_address 0x014; slave_waitrequest stays 0.
REQ-020 Hold master_waitrequest high and issue 9 writes with CMD_DEPTH=8. Required: slave_waitrequest rises after the 8th acceptance. Master outputs stay stable throughout the stall. All 9 writes emerge in order once waitrequest drops.
REQ-021 Issue 10 reads with MAX_PENDING=8 and readdatavalid withheld. Required:
- 8 reads issue and pending_count reaches 8;
- the 9th read holds;
- after one return, the 9th read issues on the following cycle.
REQ-022 Issue a read, then return master_readdata 0x12345678 with endofpacket=1. Required: one cycle later, slave_readdatavalid=1, slave_readdata=0x12345678, slave_endofpacket=1; pending_count returns to 0.
REQ-023 Pulse master_readdatavalid with nothing pending. Required: unsolicited_err=1, no slave_readdatavalid. Then assert reset during 3 pending reads. Required: all outputs 0 and pending_count 0 immediately.
